// File: rtl/mux_word_serializer.sv
// Parallel-to-serial sequencer driving a 16:1 select mux.
// Holds a word on the mux data inputs and walks the select.
module mux_word_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mux_datain,
  output logic [3:0]  mux_select,
  input  logic        mux_outd,
  output logic        ser_bit,
  output logic        ser_valid,
  output logic        ser_last,
  input  logic        ser_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_data;
  logic        r_bit;
  logic        r_valid;
  logic        r_last;

  logic        w_accept;
  logic        w_load;
  logic        w_done;
  logic        w_end;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_load   = (r_state == S_SHIFT) && (!r_valid || ser_ready);
  assign w_done   = (r_state == S_DRAIN) && r_valid && ser_ready;
  assign w_end    = (r_cnt == 4'hF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)       w_next = S_SHIFT;
      S_SHIFT: if (w_load && w_end) w_next = S_DRAIN;
      S_DRAIN: if (w_done)         w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
    busy     = (r_state != S_IDLE);
  end

  // cnt parks at 15 after the final load so the select stays put in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_data  <= 16'd0;
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data <= in_data;
        r_cnt  <= 4'd0;
      end
      if (w_load) begin
        r_bit   <= mux_outd;
        r_valid <= 1'b1;
        r_last  <= w_end;
        if (!w_end) r_cnt <= r_cnt + 4'd1;
      end
      if (w_done) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign mux_datain = r_data;
  assign mux_select = MSB_FIRST ? ~r_cnt : r_cnt;
  assign ser_bit    = r_bit;
  assign ser_valid  = r_valid;
  assign ser_last   = r_last;

endmodule

// File: tb/tb_mux_word_serializer.sv
// Bench for mux_word_serializer: LSB-first and MSB-first instances
// share stimulus, each fed by its own behavioural 16:1 mux.
module tb_mux_word_serializer;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        ser_ready;

  logic        in_ready0, in_ready1;
  logic [15:0] din0, din1;
  logic [3:0]  sel0, sel1;
  logic        outd0, outd1;
  logic        bit0, bit1;
  logic        valid0, valid1;
  logic        last0, last1;
  logic        busy0, busy1;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] data;
    logic [15:0] seq0;
    logic [15:0] seq1;
    int          stall_bit;
    int          stall_n;
    int          last_n;
    int          period;
  } vec_t;

  vec_t tbl [5];

  assign outd0 = din0[sel0];
  assign outd1 = din1[sel1];

  mux_word_serializer #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .mux_datain(din0), .mux_select(sel0), .mux_outd(outd0),
    .ser_bit(bit0), .ser_valid(valid0), .ser_last(last0),
    .ser_ready(ser_ready), .busy(busy0)
  );

  mux_word_serializer #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .mux_datain(din1), .mux_select(sel1), .mux_outd(outd1),
    .ser_bit(bit1), .ser_valid(valid1), .ser_last(last1),
    .ser_ready(ser_ready), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input vec_t v);
    int idx;
    int sm;
    int sl;
    int per;
    logic [3:0] es;
    in_data   = v.data;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    chk("in_ready_idle0", in_ready0, 1);
    chk("in_ready_idle1", in_ready1, 1);
    tick();
    in_valid = 1'b0;
    chk("busy_c1", busy0, 1);
    chk("in_ready_c1", in_ready0, 0);
    chk("valid_c1", valid0, 0);
    chk("sel0_start", sel0, 0);
    chk("sel1_start", sel1, 15);
    chk("datain0", din0, v.data);
    chk("datain1", din1, v.data);
    idx = 0;
    sm  = 0;
    sl  = 0;
    per = 0;
    for (int c = 1; c < 60 && per == 0; c++) begin
      if (in_ready0) begin
        per = c;
      end else begin
        if (valid0 && idx == v.stall_bit && sm < v.stall_n) begin
          ser_ready = 1'b0;
          sm++;
        end else if (valid0 && idx == 15 && sl < v.last_n) begin
          ser_ready = 1'b0;
          sl++;
        end else begin
          ser_ready = 1'b1;
        end
        if (valid0) begin
          if (idx > 15) begin
            chk("extra_bit", idx, 15);
          end else begin
            es = (idx == 15) ? 4'd15 : 4'(idx + 1);
            chk("ser_bit0", bit0, v.seq0[idx]);
            chk("ser_bit1", bit1, v.seq1[idx]);
            chk("ser_last0", last0, (idx == 15) ? 1 : 0);
            chk("ser_last1", last1, (idx == 15) ? 1 : 0);
            chk("sel0_step", sel0, es);
            chk("sel1_step", sel1, 4'(15 - es));
            chk("datain_hold", din0, v.data);
          end
          if (ser_ready) idx++;
        end
        tick();
      end
    end
    ser_ready = 1'b1;
    chk("bit_count", idx, 16);
    chk("period", per, v.period);
    chk("valid_after", valid0, 0);
    chk("busy_after", busy0, 0);
  endtask

  task automatic back_to_back();
    int per;
    int n;
    in_data   = 16'hFFFF;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    tick();
    in_data = 16'h0000;
    per = 0;
    n   = 0;
    for (int c = 1; c < 40 && per == 0; c++) begin
      if (in_ready0) begin
        per = c;
      end else begin
        if (valid0) begin
          chk("b2b_ones", bit0, 1);
          n++;
        end
        if (c == 10) chk("b2b_hold", din0, 16'hFFFF);
        tick();
      end
    end
    chk("b2b_accept2", per, 18);
    chk("b2b_n1", n, 16);
    tick();
    in_valid = 1'b0;
    chk("b2b_datain2", din0, 16'h0000);
    chk("b2b_busy2", busy0, 1);
    per = 0;
    n   = 0;
    for (int c = 19; c < 60 && per == 0; c++) begin
      if (in_ready0) begin
        per = c;
      end else begin
        if (valid0) begin
          chk("b2b_zeros", bit0, 0);
          n++;
        end
        tick();
      end
    end
    chk("b2b_end2", per, 36);
    chk("b2b_n2", n, 16);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_data   = 16'h0;
    in_valid  = 1'b0;
    ser_ready = 1'b1;

    tbl[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5, 0, 0, 0, 18};
    tbl[1] = '{16'h6B1E, 16'h6B1E, 16'h78D6, 0, 0, 0, 18};
    tbl[2] = '{16'h8001, 16'h8001, 16'h8001, 5, 3, 2, 23};
    tbl[3] = '{16'hF0F0, 16'hF0F0, 16'h0F0F, 0, 1, 0, 19};
    tbl[4] = '{16'h00FF, 16'h00FF, 16'hFF00, 0, 0, 0, 18};

    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_datain", din0, 0);
    chk("rst_sel0", sel0, 0);
    chk("rst_sel1", sel1, 15);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_word(tbl[i]);
      tick();
    end

    back_to_back();
    tick();

    in_data  = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_valid", valid0, 1);
    chk("mid_bit7", bit0, 0);
    chk("mid_sel", sel0, 8);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid0, 0);
    chk("mid_rst_last", last0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_ready", in_ready0, 1);
    chk("mid_rst_sel0", sel0, 0);
    chk("mid_rst_sel1", sel1, 15);
    chk("mid_rst_datain", din0, 0);
    #2 rst = 1'b0;
    tick();
    run_word(tbl[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_word_serializer.md
# mux_word_serializer

Parallel-to-serial sequencer that sits directly upstream of the 16:1 select mux. It accepts a 16-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the 4-bit select through all 16 positions, one per cycle, and samples the mux output back into a registered serial stream with valid/ready backpressure and an end-of-word marker.

## Interface
- MSB_FIRST, 0, 0: select counts 0→15 (bit 0 first); 1: select counts 15→0 (bit 15 first)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  16  word to serialize
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a word (high only in IDLE)
- mux_datain  out  16  held word, drives the mux data inputs
- mux_select  out  4  registered select, drives the mux select
- mux_outd  in  1  combinational mux output for current mux_select
- ser_bit  out  1  registered serial data bit
- ser_valid  out  1  ser_bit is valid
- ser_last  out  1  ser_bit is the 16th bit of the word
- ser_ready  in  1  downstream accepts ser_bit this cycle
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SHIFT, DRAIN. Internal 4-bit counter cnt. mux_select = cnt when MSB_FIRST=0, ~cnt when MSB_FIRST=1.
- Reset (async): state=IDLE, cnt=0, mux_datain=0, ser_bit=0, ser_valid=0, ser_last=0. Outputs are in_ready=1, busy=0, and mux_select=0 (15 if MSB_FIRST).
- IDLE: in_ready=1. On in_valid: mux_datain<=in_data, cnt<=0, and the next state is SHIFT. Otherwise mux_datain holds its value.
- SHIFT: the output register may load when !ser_valid || ser_ready. On load:
  - ser_bit<=mux_outd, ser_valid<=1, ser_last<=(cnt==15).
  - If cnt==15, the next state is DRAIN; otherwise cnt<=cnt+1.
- SHIFT with no load (ser_valid && !ser_ready): cnt, mux_select, and the output register all hold.
- DRAIN: when ser_valid && ser_ready, ser_valid<=0, ser_last<=0, and the next state is IDLE. Otherwise everything holds.
- mux_datain is stable from the word-accept edge until the next accept. mux_select changes only on a SHIFT load (or on accept, when it returns to the start value).
- ser_bit, ser_valid, and ser_last never change while ser_valid && !ser_ready.
- cnt does not wrap within a word. It is 15 only on the final load.
- Reset asserted mid-word: the word is dropped immediately, with no partial ser_last. The first word after reset starts at select position 0 (15 if MSB_FIRST).

## Timing
- Accept edge at cycle 0 (in_valid && in_ready). The block is in SHIFT from cycle 1, with mux_select at its start value.
- With ser_ready=1 throughout: bit k appears on ser_bit with ser_valid=1 in cycle k+2, and ser_last=1 in cycle 17. State is DRAIN in cycle 17, and in_ready=1 in cycle 18.
- Word-to-word period without stalls: 18 cycles (accept, 16 SHIFT, 1 DRAIN).
- Each cycle of ser_ready=0 while ser_valid=1 adds exactly one cycle. No bit is lost or duplicated.
- ser_valid is 0 in cycle 1 of every word. A ser_ready sampled while ser_valid=0 has no effect.
- Latency from mux_select to ser_bit: 1 cycle (mux_outd is sampled on the edge ending the cycle the select is presented).

## Test plan
- Reset: assert rst mid-clock -> immediately in_ready=1, busy=0, ser_valid=0, mux_datain=0, mux_select=0.
- MSB_FIRST=0, in_data=0xA5C3, ser_ready=1 -> ser_bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 in cycles 2..17, ser_last only in cycle 17, in_ready=1 in cycle 18.
- MSB_FIRST=1, in_data=0xA5C3 -> sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, mux_select 15→0.
- Backpressure: 0x8001 with ser_ready low for 3 cycles at bit 5 and low 2 cycles at ser_last -> bits 5 and 15 held stable with mux_select frozen, total 16 transfers, word period 23 cycles.
- Back-to-back: in_valid held high with 0xFFFF then 0x0000 -> second accept exactly in cycle 18, 16 ones then 16 zeros, in_ready low throughout each word.
- Reset at bit 7 of 0x1234 -> ser_valid=0 at once. The next word 0x00FF starts at select 0 and serializes fully and correctly.
